// File: rtl/rat_io_pkg.sv
// Shared constants for the RAT I/O responder: port map and default data width.
package rat_io_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [7:0] LEDS_ID     = 8'h40;
  localparam logic [7:0] SSEG_ID     = 8'h81;
  localparam logic [7:0] SW_ID       = 8'h20;
  localparam logic [7:0] BTN_ID      = 8'hFF;
  localparam logic [7:0] INT_ACK_ID  = 8'h21;
  localparam logic [7:0] INT_PEND_ID = 8'h22;
  localparam logic [7:0] INT_MASK_ID = 8'h23;

  // A register write is qualified by the strobe and an exact ID match.
  function automatic logic wr_hit(input logic strb, input logic [7:0] id, input logic [7:0] target);
    return strb && (id == target);
  endfunction

endpackage

// File: rtl/rat_io_responder_if.sv
// MCU-side I/O bus: the MCU is the master, the responder is the slave.
interface rat_io_responder_if
  import rat_io_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [7:0]        PORT_ID;
  logic [DATA_W-1:0] OUT_PORT;
  logic              IO_STRB;
  logic [DATA_W-1:0] IN_PORT;

  modport master (output PORT_ID, output OUT_PORT, output IO_STRB, input IN_PORT);
  modport slave  (input PORT_ID, input OUT_PORT, input IO_STRB, output IN_PORT);
endinterface

// File: rtl/rat_btn_debounce.sv
// Single-bit synchroniser followed by a stability counter; the stable bit only
// toggles after the synchronised input has disagreed for DEBOUNCE_CYCLES cycles.
module rat_btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic btn_async,
  output logic btn_stable,
  output logic btn_rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   stable_r;
  logic                   mismatch_s;
  logic                   expire_s;

  assign mismatch_s = sync_r[SYNC_STAGES-1] ^ stable_r;
  assign expire_s   = mismatch_s && (cnt_r == CNT_LAST);
  assign btn_stable = stable_r;
  // Rise is flagged on the same edge the stable bit goes high.
  assign btn_rise   = expire_s && !stable_r;

  // Input synchroniser chain.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn_async};
    end
  end

  // Debounce counter and accepted value; the counter saturates instead of wrapping.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r    <= '0;
      stable_r <= 1'b0;
    end else if (!mismatch_s) begin
      cnt_r <= '0;
    end else if (expire_s) begin
      stable_r <= !stable_r;
      cnt_r    <= '0;
    end else if (cnt_r != {CNT_W{1'b1}}) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rat_io_responder.sv
// Peripheral responder on the RAT MCU I/O bus: LED/seven-segment registers,
// synchronised switches, debounced buttons. Define RAT_IO_INT_EN for button interrupts.
module rat_io_responder
  import rat_io_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                CLK,
  input  logic                RESET_N,
  rat_io_responder_if.slave   io,
  input  logic [DATA_W-1:0]   SWITCHES,
  input  logic [N_BTN-1:0]    BUTTONS,
  output logic [DATA_W-1:0]   LEDS,
  output logic [DATA_W-1:0]   SSEG,
  output logic                INT_R
);
  logic [DATA_W-1:0] leds_r;
  logic [DATA_W-1:0] sseg_r;
  logic [DATA_W-1:0] sw_sync_r [SYNC_STAGES];
  logic [N_BTN-1:0]  btn_stable_s;
  logic [N_BTN-1:0]  btn_rise_s;
  logic [DATA_W-1:0] pend_rd_s;
  logic [DATA_W-1:0] mask_rd_s;
  logic [DATA_W-1:0] rd_mux_s;

  assign LEDS = leds_r;
  assign SSEG = sseg_r;

  // Output registers written by OUT instructions.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      leds_r <= '0;
      sseg_r <= '0;
    end else begin
      if (wr_hit(io.IO_STRB, io.PORT_ID, LEDS_ID)) leds_r <= io.OUT_PORT;
      if (wr_hit(io.IO_STRB, io.PORT_ID, SSEG_ID)) sseg_r <= io.OUT_PORT;
    end
  end

  // Switch synchroniser; switches are read raw, without debounce.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_r[i] <= '0;
    end else begin
      sw_sync_r[0] <= SWITCHES;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync_r[i] <= sw_sync_r[i-1];
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    rat_btn_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .btn_async  (BUTTONS[g]),
      .btn_stable (btn_stable_s[g]),
      .btn_rise   (btn_rise_s[g])
    );
  end

`ifdef RAT_IO_INT_EN
  logic [N_BTN-1:0]  pending_r;
  logic [DATA_W-1:0] mask_r;
  logic              int_r;
  logic [N_BTN-1:0]  ack_s;

  assign ack_s     = wr_hit(io.IO_STRB, io.PORT_ID, INT_ACK_ID) ? io.OUT_PORT[N_BTN-1:0] : '0;
  assign pend_rd_s = DATA_W'(pending_r);
  assign mask_rd_s = mask_r;
  assign INT_R     = int_r;

  // Pending/mask state; a new rising edge beats a simultaneous acknowledge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending_r <= '0;
      mask_r    <= '0;
      int_r     <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~ack_s) | btn_rise_s;
      if (wr_hit(io.IO_STRB, io.PORT_ID, INT_MASK_ID)) mask_r <= io.OUT_PORT;
      int_r <= |(pending_r & mask_r[N_BTN-1:0]);
    end
  end
`else
  logic unused_rise_s;

  assign unused_rise_s = ^btn_rise_s;
  assign pend_rd_s     = '0;
  assign mask_rd_s     = '0;
  assign INT_R         = 1'b0;
`endif

  // Zero-latency read mux over registered sources.
  always_comb begin
    rd_mux_s = '0;
    case (io.PORT_ID)
      SW_ID:       rd_mux_s = sw_sync_r[SYNC_STAGES-1];
      BTN_ID:      rd_mux_s = DATA_W'(btn_stable_s);
      INT_PEND_ID: rd_mux_s = pend_rd_s;
      INT_MASK_ID: rd_mux_s = mask_rd_s;
      default:     rd_mux_s = '0;
    endcase
  end

  assign io.IN_PORT = rd_mux_s;

endmodule

// File: tb/tb_rat_io_responder.sv
// Directed scoreboard bench for rat_io_responder; interrupt expectations follow RAT_IO_INT_EN.
module tb_rat_io_responder;
  import rat_io_pkg::*;

  localparam int DW = 8;
  localparam int NB = 4;
`ifdef RAT_IO_INT_EN
  localparam bit INT_ON = 1'b1;
`else
  localparam bit INT_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [DW-1:0] SWITCHES;
  logic [NB-1:0] BUTTONS;
  logic [DW-1:0] LEDS;
  logic [DW-1:0] SSEG;
  logic          INT_R;

  rat_io_responder_if #(.DATA_W(DW)) bus ();

  rat_io_responder #(
    .DATA_W          (DW),
    .N_BTN           (NB),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .io       (bus),
    .SWITCHES (SWITCHES),
    .BUTTONS  (BUTTONS),
    .LEDS     (LEDS),
    .SSEG     (SSEG),
    .INT_R    (INT_R)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  chk_cnt = 0;
  int  err_cnt = 0;

  task automatic sb_push(input string tag, input logic [7:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [7:0] obs);
    sb_t e;
    chk_cnt++;
    if (sb_q.size() == 0) begin
      err_cnt++;
      $error("FAIL sb_empty: observed %02h expected <queued entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        err_cnt++;
        $error("FAIL %s: observed %02h expected %02h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    bus.PORT_ID  = id;
    bus.OUT_PORT = data;
    bus.IO_STRB  = 1'b1;
    step(1);
    bus.IO_STRB  = 1'b0;
  endtask

  task automatic rd_check(input logic [7:0] id);
    bus.PORT_ID = id;
    #1;
    sb_check(bus.IN_PORT);
  endtask

  initial begin
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;
    SWITCHES     = 8'h00;
    BUTTONS      = 4'h0;

    // Reset state
    #3;
    sb_push("rst_leds", 8'h00);  sb_check(LEDS);
    sb_push("rst_sseg", 8'h00);  sb_check(SSEG);
    sb_push("rst_int_r", 8'h00); sb_check({7'b0, INT_R});
    sb_push("rst_btn_rd", 8'h00); rd_check(BTN_ID);
    #7 RESET_N = 1'b1;
    step(2);

    // Write decode
    sb_push("leds_wr", 8'h3C);
    wr(LEDS_ID, 8'h3C);
    sb_check(LEDS);
    sb_push("leds_unmapped_41", 8'h3C);
    wr(8'h41, 8'hC3);
    sb_check(LEDS);
    sb_push("leds_ro_write", 8'h3C);
    sb_push("sseg_ro_write", 8'h00);
    wr(SW_ID, 8'h77);
    sb_check(LEDS);
    sb_check(SSEG);
    sb_push("sseg_no_strb", 8'h00);
    bus.PORT_ID  = SSEG_ID;
    bus.OUT_PORT = 8'h99;
    step(1);
    sb_check(SSEG);
    sb_push("sseg_wr", 8'h99);
    wr(SSEG_ID, 8'h99);
    sb_check(SSEG);

    // Switch read with two-stage synchroniser latency
    SWITCHES    = 8'h96;
    bus.PORT_ID = SW_ID;
    step(1);
    sb_push("sw_lat1", 8'h00);   rd_check(SW_ID);
    step(1);
    sb_push("sw_lat2", 8'h96);   rd_check(SW_ID);
    sb_push("unmapped_rd", 8'h00); rd_check(8'h10);

    // Ten-cycle glitch on BUTTONS[0] must never be accepted
    BUTTONS[0] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (i == 10) BUTTONS[0] = 1'b0;
      sb_push("btn_glitch", 8'h00);
      rd_check(BTN_ID);
    end
    step(20);

    // Held press accepted exactly 2+16 cycles after the edge
    BUTTONS[0] = 1'b1;
    step(17);
    sb_push("btn_hold_17", 8'h00); rd_check(BTN_ID);
    step(1);
    sb_push("btn_hold_18", 8'h01); rd_check(BTN_ID);
    step(12);
    BUTTONS[0] = 1'b0;
    step(20);
    sb_push("btn_release", 8'h00); rd_check(BTN_ID);

    // Interrupt: mask, press, pending, request
    wr(INT_MASK_ID, 8'h02);
    sb_push("mask_rd", INT_ON ? 8'h02 : 8'h00); rd_check(INT_MASK_ID);
    BUTTONS[1] = 1'b1;
    step(18);
    sb_push("pend_set", INT_ON ? 8'h02 : 8'h00); rd_check(INT_PEND_ID);
    sb_push("int_r_before", 8'h00); sb_check({7'b0, INT_R});
    step(1);
    sb_push("int_r_set", {7'b0, INT_ON}); sb_check({7'b0, INT_R});
    sb_push("btn1_rd", 8'h02); rd_check(BTN_ID);

    // Acknowledge clears pending; request drops one cycle later
    wr(INT_ACK_ID, 8'h02);
    sb_push("int_r_ack0", {7'b0, INT_ON}); sb_check({7'b0, INT_R});
    sb_push("pend_ack", 8'h00); rd_check(INT_PEND_ID);
    step(1);
    sb_push("int_r_ack1", 8'h00); sb_check({7'b0, INT_R});

    // Acknowledge on the same edge as a new rising edge: set wins
    BUTTONS[1] = 1'b0;
    step(20);
    BUTTONS[1] = 1'b1;
    step(17);
    wr(INT_ACK_ID, 8'h02);
    sb_push("pend_set_wins", INT_ON ? 8'h02 : 8'h00); rd_check(INT_PEND_ID);
    step(1);
    sb_push("int_r_set_wins", {7'b0, INT_ON}); sb_check({7'b0, INT_R});

    // Asynchronous reset mid-run
    wr(LEDS_ID, 8'hA5);
    sb_push("leds_a5", 8'hA5); sb_check(LEDS);
    wr(SSEG_ID, 8'h5A);
    bus.PORT_ID = BTN_ID;
    step(1);
    #2 RESET_N = 1'b0;
    #1;
    sb_push("mid_rst_leds", 8'h00);  sb_check(LEDS);
    sb_push("mid_rst_sseg", 8'h00);  sb_check(SSEG);
    sb_push("mid_rst_int_r", 8'h00); sb_check({7'b0, INT_R});
    sb_push("mid_rst_btn", 8'h00);   rd_check(BTN_ID);
    #2 RESET_N = 1'b1;
    step(2);
    sb_push("post_rst_leds", 8'h00); sb_check(LEDS);

    chk_cnt++;
    assert (sb_q.size() == 0) else begin
      err_cnt++;
      $error("FAIL sb_leftover: observed %0d expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
